serial_logic_unit: RTL and testbench

//  Bit-serial counterpart of the ALU's parallel bitwise logic slice: accepts two

---
 rtl/slu_pkg.sv | 18 +
 rtl/bitwise_logic_cell.sv | 23 ++
 rtl/serial_logic_unit.sv | 110 +++++++++++
 tb/tb_serial_logic_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/slu_pkg.sv
// Shared encodings for the bit-serial logic unit.
// Op and state codes are reused by the ALU decoder.
package slu_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } slu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } slu_state_e;

endpackage

// File: rtl/bitwise_logic_cell.sv
// Single 1-bit logic cell shared by every bit position.
// Purely combinational: y = f(op, a, b).
module bitwise_logic_cell
  import slu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  slu_op_e op,
  output logic    y
);

  // Decode the latched opcode into one bit operation
  always_comb begin
    y = 1'b0;
    unique case (1'b1)
      (op == OP_OR):  y = a | b;
      (op == OP_AND): y = a & b;
      (op == OP_XOR): y = a ^ b;
      (op == OP_NOR): y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit, LSB first, one bit per clock.
// Optional zero flag port enabled by defining SLU_ZERO_FLAG_EN.
module serial_logic_unit
  import slu_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
`ifdef SLU_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  slu_state_e       state;
  slu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  slu_op_e          op_r;
  logic             bit_y;
  logic [WIDTH-1:0] o_upd;
  logic             accept;
  logic             last;
  logic             take;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_LAST);
  assign take     = out_valid && out_ready;

  bitwise_logic_cell u_cell (
    .a  (a_r[cnt]),
    .b  (b_r[cnt]),
    .op (op_r),
    .y  (bit_y)
  );

  // Result with the current bit position replaced by the cell output
  always_comb begin
    o_upd      = o;
    o_upd[cnt] = bit_y;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (last)   state_nxt = S_DONE;
      S_DONE:  if (take)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit counter, result and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_OR;
      cnt       <= '0;
      o         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b;
      op_r <= slu_op_e'(op);
      cnt  <= '0;
      o    <= '0;
    end else if (state == S_SHIFT) begin
      o   <= o_upd;
      cnt <= last ? '0 : cnt + CNT_ONE;
      if (last) out_valid <= 1'b1;
    end else if (state == S_DONE && take) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SLU_ZERO_FLAG_EN
  // Zero flag follows the final result into DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero <= 1'b0;
    else if (state == S_SHIFT && last)
      zero <= (o_upd == '0);
  end
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit (WIDTH=4).
// Vector table plus hand sequences for reset and hold cases.
module tb_serial_logic_unit;
  import slu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o;
  logic         busy;
`ifdef SLU_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_o;
    logic         exp_z;
    int           stall;
  } vec_t;

  vec_t vecs[9];

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
`ifdef SLU_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  lat;
    bit  hold_ok;
    wait_ready();
    in_valid = 1'b1;
    a  = v.a;
    b  = v.b;
    op = v.op;
    tick();
    in_valid = 1'b0;
    a  = ~v.a;
    b  = ~v.b;
    op = v.op + 2'd1;
    chk("busy_after_accept", 32'(busy), 1);
    wait_valid(lat);
    chk("latency", lat, W);
    chk("result", 32'(o), 32'(v.exp_o));
`ifdef SLU_ZERO_FLAG_EN
    chk("zero", 32'(zero), 32'(v.exp_z));
`endif
    hold_ok = 1'b1;
    for (int i = 0; i < v.stall; i++) begin
      tick();
      if (!out_valid || o !== v.exp_o)
        hold_ok = 1'b0;
    end
    if (v.stall > 0)
      chk("stall_hold", 32'(hold_ok), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 0);
    chk("idle_ready", 32'(in_ready), 1);
    chk("o_kept", 32'(o), 32'(v.exp_o));
  endtask

  initial begin
    int  lat;
    bit  ghost;
    bit  leak;

    vecs[0] = '{4'h6, 4'h4, OP_OR,  4'h6, 1'b0, 0};
    vecs[1] = '{4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 0};
    vecs[2] = '{4'hC, 4'hA, OP_XOR, 4'h6, 1'b0, 0};
    vecs[3] = '{4'hC, 4'hA, OP_NOR, 4'h1, 1'b0, 0};
    vecs[4] = '{4'h5, 4'h3, OP_AND, 4'h1, 1'b0, 10};
    vecs[5] = '{4'h0, 4'h0, OP_OR,  4'h0, 1'b1, 0};
    vecs[6] = '{4'h1, 4'h0, OP_OR,  4'h1, 1'b0, 0};
    vecs[7] = '{4'hF, 4'hF, OP_NOR, 4'h0, 1'b1, 2};
    vecs[8] = '{4'h5, 4'h5, OP_XOR, 4'h0, 1'b1, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a  = '0;
    b  = '0;
    op = '0;
    repeat (2) @(negedge clk);
    chk("rst_o", 32'(o), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
`ifdef SLU_ZERO_FLAG_EN
    chk("rst_zero", 32'(zero), 0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i]);

    // Reset in the middle of SHIFT
    wait_ready();
    in_valid = 1'b1;
    a  = 4'h9;
    b  = 4'h6;
    op = OP_OR;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_o", 32'(o), 32'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_o", 32'(o), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    ghost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || busy) ghost = 1'b1;
    end
    chk("no_ghost", 32'(ghost), 0);
    run_vec('{4'hF, 4'h0, OP_XOR, 4'hF, 1'b0, 0});

    // Request held high across a running op
    wait_ready();
    in_valid = 1'b1;
    a  = 4'h1;
    b  = 4'h2;
    op = OP_OR;
    tick();
    a = 4'hF;
    b = 4'hF;
    leak = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) leak = 1'b1;
      tick();
      lat++;
    end
    chk("held_ignored", 32'(leak), 0);
    chk("held_latency", lat, W);
    chk("held_o", 32'(o), 32'h3);
    chk("done_not_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("held_idle", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("held_accepted", 32'(busy), 1);
    wait_valid(lat);
    chk("held2_latency", lat, W);
    chk("held2_o", 32'(o), 32'hF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("held2_drop", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
